wb_team_interconnect: RTL

Registered Wishbone (classic, single outstanding transfer) interconnect sitting between the Caravel management-core Wishbone master and the user-area slaves: GPIO control, LA control and NUM_TEAMS team wrappers. It decodes the address into one slave strobe and truncates the address. It returns the selected slave's data and ack, and terminates unmapped or hung transfers with an error word so the master never stalls. It adds a timeout watchdog, error reporting and abort handling.

---
 rtl/wb_team_interconnect.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/wb_team_interconnect.sv
// Registered Wishbone interconnect: decodes the management-core address into one
// user-area slave strobe and guarantees every accepted transfer terminates.
module wb_team_interconnect #(
  parameter int          NUM_TEAMS      = 12,
  parameter logic [7:0]  BASE_HI        = 8'h30,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hBADB_0DE5
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic [31:0]               wbs_adr_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic [31:0]               adr_truncated,
  output logic                      gpio_control_stb,
  output logic                      la_control_stb,
  output logic [NUM_TEAMS-1:0]      designs_stb,
  input  logic                      gpio_control_ack_o,
  input  logic                      la_control_ack_o,
  input  logic [NUM_TEAMS-1:0]      designs_ack_o,
  input  logic [31:0]               gpio_control_dat_o,
  input  logic [31:0]               la_control_dat_o,
  input  logic [32*NUM_TEAMS-1:0]   designs_wbs_dat_o_flat,
  output logic                      err_pulse,
  output logic [7:0]                timeout_count
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  slot_q, slot_d;
  logic [15:0] adr_q, adr_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] dat_q, dat_d;
  logic        err_q, err_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic        req_mapped;
  logic        sel_ack;
  logic [31:0] sel_dat;

  assign req_mapped = (wbs_adr_i[31:24] == BASE_HI) &&
                      (int'(wbs_adr_i[23:16]) <= NUM_TEAMS + 1);

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    if (slot_q == 8'd0) begin
      sel_ack = gpio_control_ack_o;
      sel_dat = gpio_control_dat_o;
    end else if (slot_q == 8'd1) begin
      sel_ack = la_control_ack_o;
      sel_dat = la_control_dat_o;
    end
    for (int k = 0; k < NUM_TEAMS; k++) begin
      if (slot_q == 8'(k + 2)) begin
        sel_ack = designs_ack_o[k];
        sel_dat = designs_wbs_dat_o_flat[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    adr_d   = adr_q;
    timer_d = timer_q;
    dat_d   = dat_q;
    err_d   = err_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          slot_d  = wbs_adr_i[23:16];
          adr_d   = wbs_adr_i[15:0];
          timer_d = '0;
          if (req_mapped) begin
            state_d = BUSY;
            err_d   = 1'b0;
          end else begin
            state_d = RESP;
            dat_d   = ERR_DATA;
            err_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        timer_d = timer_q + 16'd1;
        // Abort outranks a coincident ack: the master has already left the cycle.
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (sel_ack) begin
          state_d = RESP;
          dat_d   = sel_dat;
          err_d   = 1'b0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = RESP;
          dat_d   = ERR_DATA;
          err_d   = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      slot_q  <= '0;
      adr_q   <= '0;
      timer_q <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      adr_q   <= adr_d;
      timer_q <= timer_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Strobes derive only from registered state, so slaves see no input glitches.
  always_comb begin
    designs_stb = '0;
    for (int k = 0; k < NUM_TEAMS; k++) begin
      designs_stb[k] = (state_q == BUSY) && (slot_q == 8'(k + 2));
    end
  end

  assign gpio_control_stb = (state_q == BUSY) && (slot_q == 8'd0);
  assign la_control_stb   = (state_q == BUSY) && (slot_q == 8'd1);
  assign wbs_ack_o        = (state_q == RESP);
  assign err_pulse        = (state_q == RESP) && err_q;
  assign wbs_dat_o        = dat_q;
  assign adr_truncated    = {16'h0, adr_q};
  assign timeout_count    = tcnt_q;

endmodule
